// File: rtl/mbssoc_irq_collector.sv
// Interrupt request front end for the APIC: synchronises device lines, merges
// per-core syscall requests and presents a masked pending vector plus held codes.
module mbssoc_irq_collector #(
  parameter int                       INT_SEL_WIDTH = 8,
  parameter int                       SYSCODE_WIDTH = 8,
  parameter int                       SC0_BIT       = 0,
  parameter int                       SC1_BIT       = 1,
  parameter logic [INT_SEL_WIDTH-1:0] EDGE_MASK     = 8'hFC,
  parameter logic [INT_SEL_WIDTH-1:0] MASK_RST      = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INT_SEL_WIDTH-1:0] irq_in,
  input  logic [INT_SEL_WIDTH-1:0] int_ack,
  input  logic                     sys_req0,
  input  logic                     sys_req1,
  input  logic [SYSCODE_WIDTH-1:0] sys_code0,
  input  logic [SYSCODE_WIDTH-1:0] sys_code1,
  input  logic                     mask_we,
  input  logic [INT_SEL_WIDTH-1:0] mask_wdata,
  input  logic                     ovf_clr,
  output logic [INT_SEL_WIDTH-1:0] int_vec,
  output logic [SYSCODE_WIDTH-1:0] syscall_code0,
  output logic [SYSCODE_WIDTH-1:0] syscall_code1,
  output logic [1:0]               sys_busy,
  output logic [INT_SEL_WIDTH-1:0] int_ovf
);

  localparam logic [INT_SEL_WIDTH-1:0] SC_SEL =
    (INT_SEL_WIDTH'(1) << SC0_BIT) | (INT_SEL_WIDTH'(1) << SC1_BIT);
  localparam logic [INT_SEL_WIDTH-1:0] DEV_SEL = ~SC_SEL;

  logic [INT_SEL_WIDTH-1:0] sync1, sync2, prev;
  logic [INT_SEL_WIDTH-1:0] pending, mask;
  logic [INT_SEL_WIDTH-1:0] dev_set, set_vec, ovf_set;
  logic [INT_SEL_WIDTH-1:0] pending_nxt, ovf_nxt;
  logic                     sc0_acc, sc1_acc;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dev_set = sync2 & ((EDGE_MASK & ~prev) | ~EDGE_MASK) & DEV_SEL;
    // A syscall is accepted when its slot is free or being acked this edge.
    sc0_acc = sys_req0 & (~pending[SC0_BIT] | int_ack[SC0_BIT]);
    sc1_acc = sys_req1 & (~pending[SC1_BIT] | int_ack[SC1_BIT]);

    set_vec = dev_set;
    set_vec[SC0_BIT] = set_vec[SC0_BIT] | sc0_acc;
    set_vec[SC1_BIT] = set_vec[SC1_BIT] | sc1_acc;

    ovf_set = dev_set & EDGE_MASK & pending & ~int_ack;
    ovf_set[SC0_BIT] = ovf_set[SC0_BIT] | (sys_req0 & ~sc0_acc);
    ovf_set[SC1_BIT] = ovf_set[SC1_BIT] | (sys_req1 & ~sc1_acc);

    // Set wins over a coincident ack so no event is lost.
    pending_nxt = (pending & ~int_ack) | set_vec;
    ovf_nxt     = (ovf_clr ? '0 : int_ovf) | ovf_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which the synchroniser chain depends on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      prev          <= '0;
      pending       <= '0;
      int_ovf       <= '0;
      mask          <= MASK_RST;
      syscall_code0 <= '0;
      syscall_code1 <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= pending_nxt;
      int_ovf <= ovf_nxt;
      if (mask_we) mask <= mask_wdata;
      if (sc0_acc) syscall_code0 <= sys_code0;
      if (sc1_acc) syscall_code1 <= sys_code1;
    end
  end

  assign int_vec  = pending & mask;
  assign sys_busy = {pending[SC1_BIT], pending[SC0_BIT]};

endmodule
